// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half-add stages and an OR for the carry.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    assign w_s1 = a ^ b;
    assign w_c1 = a & b;
    assign sum  = w_s1 ^ cin;
    assign w_c2 = w_s1 & cin;
    assign cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell reused once per SHIFT cycle, LSB first.
// Operand A's register doubles as the result shift register as its bits are consumed.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    state_e            r_state;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_b;
    logic [CntW-1:0]   r_cnt;
    logic              r_carry;
    logic              r_sub;

    logic              w_b_bit;
    logic              w_sum;
    logic              w_cout;
    logic              w_last;

    // Subtraction is A + ~B + 1: invert B here, the +1 comes from the preset carry.
    assign w_b_bit = (r_sub == SUB) ? ~r_b[0] : r_b[0];
    assign w_last  = (r_cnt == CntW'(WIDTH - 1));

    full_adder_cell u_fa (
        .a    (r_acc[0]),
        .b    (w_b_bit),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_acc      <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_sub      <= ADD;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_sum      <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_acc   <= i_a;
                        r_b     <= i_b;
                        r_sub   <= i_sub;
                        r_cnt   <= '0;
                        r_carry <= i_sub;
                        o_busy  <= 1'b1;
                        r_state <= StShift;
                    end
                end
                StShift: begin
                    r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CntW'(1);
                    if (w_last) begin
                        // r_carry is the carry into the MSB, w_cout the carry out of it.
                        o_sum      <= {w_sum, r_acc[WIDTH-1:1]};
                        o_carry    <= w_cout;
                        o_overflow <= r_carry ^ w_cout;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        r_state    <= StDone;
                    end
                end
                StDone: begin
                    o_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: arithmetic reference model checked every cycle plus literal cases.
module tb_serial_adder;

    localparam int W8  = 8;
    localparam int W16 = 16;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        s8, sub8, busy8, done8, carry8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        s16, sub16, busy16, done16, carry16, ovf16;
    logic [15:0] a16, b16, sum16;

    int vectors    = 0;
    int miscompares = 0;

    serial_adder #(.WIDTH(W8)) u_dut8 (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (s8),
        .i_a        (a8),
        .i_b        (b8),
        .i_sub      (sub8),
        .o_busy     (busy8),
        .o_done     (done8),
        .o_sum      (sum8),
        .o_carry    (carry8),
        .o_overflow (ovf8)
    );

    serial_adder #(.WIDTH(W16)) u_dut16 (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (s16),
        .i_a        (a16),
        .i_b        (b16),
        .i_sub      (sub16),
        .o_busy     (busy16),
        .o_done     (done16),
        .o_sum      (sum16),
        .o_carry    (carry16),
        .o_overflow (ovf16)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Returns {overflow, carry/no-borrow, sum} from signed/unsigned integer arithmetic.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic sub);
        longint unsigned ua, ub, md;
        longint          sa, sb, res, lo, hi;
        logic [31:0]     s;
        logic            c, o;
        md = 64'd1 << w;
        ua = 64'(a);
        ub = 64'(b);
        sa = a[w-1] ? longint'(ua) - longint'(md) : longint'(ua);
        sb = b[w-1] ? longint'(ub) - longint'(md) : longint'(ub);
        res = sub ? sa - sb : sa + sb;
        hi = longint'(md) / 2 - 1;
        lo = -(longint'(md) / 2);
        o = (res < lo) || (res > hi);
        if (sub) begin
            c = (ua >= ub);
            s = 32'((ua - ub + md) % md);
        end else begin
            c = (ua + ub) >= md;
            s = 32'((ua + ub) % md);
        end
        return {o, c, s};
    endfunction

    // Timeline model of the 8-bit DUT: m_cnt counts edges since the accepting edge (0 = idle).
    int          m_cnt;
    logic [7:0]  m_a, m_b, e_sum;
    logic        m_sub, e_carry, e_ovf;
    logic [33:0] w_ref8;

    assign w_ref8 = ref_op(W8, {24'd0, m_a}, {24'd0, m_b}, m_sub);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   <= 0;
            e_sum   <= 8'h00;
            e_carry <= 1'b0;
            e_ovf   <= 1'b0;
        end else if (m_cnt == 0) begin
            if (s8) begin
                m_a   <= a8;
                m_b   <= b8;
                m_sub <= sub8;
                m_cnt <= 1;
            end
        end else if (m_cnt == W8 + 1) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == W8) begin
                e_sum   <= w_ref8[7:0];
                e_carry <= w_ref8[32];
                e_ovf   <= w_ref8[33];
            end
        end
    end

    always @(negedge clk) begin
        check("busy8", {31'd0, busy8}, {31'd0, (m_cnt >= 1 && m_cnt <= W8)});
        check("done8", {31'd0, done8}, {31'd0, (m_cnt == W8 + 1)});
        check("sum8", {24'd0, sum8}, {24'd0, e_sum});
        check("carry8", {31'd0, carry8}, {31'd0, e_carry});
        check("ovf8", {31'd0, ovf8}, {31'd0, e_ovf});
        check("busy_done_excl", {31'd0, busy8 & done8}, 32'd0);
    end

    // Counting the accepting edge, done is seen after WIDTH+1 edges.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input logic [7:0] es, input logic ec, input logic eo,
                          input string name);
        int edges;
        bit seen;
        @(negedge clk);
        s8 = 1'b1; a8 = a; b8 = b; sub8 = sub;
        @(negedge clk);
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        edges = 1;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            if (done8) seen = 1'b1;
            else begin
                @(negedge clk);
                edges++;
            end
        end
        check({name, "_latency"}, 32'(edges), 32'(W8 + 1));
        check({name, "_sum"}, {24'd0, sum8}, {24'd0, es});
        check({name, "_carry"}, {31'd0, carry8}, {31'd0, ec});
        check({name, "_ovf"}, {31'd0, ovf8}, {31'd0, eo});
        @(negedge clk);
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input logic [15:0] es, input logic ec, input logic eo,
                           input string name);
        int edges;
        bit seen;
        @(negedge clk);
        s16 = 1'b1; a16 = a; b16 = b; sub16 = sub;
        @(negedge clk);
        s16 = 1'b0; a16 = 16'($urandom);
        edges = 1;
        seen  = 1'b0;
        while (!seen && edges < 60) begin
            if (done16) seen = 1'b1;
            else begin
                @(negedge clk);
                edges++;
            end
        end
        check({name, "_latency"}, 32'(edges), 32'(W16 + 1));
        check({name, "_sum"}, {16'd0, sum16}, {16'd0, es});
        check({name, "_carry"}, {31'd0, carry16}, {31'd0, ec});
        check({name, "_ovf"}, {31'd0, ovf16}, {31'd0, eo});
        @(negedge clk);
    endtask

    initial begin
        logic [33:0] r;
        logic [7:0]  ra, rb;
        logic [15:0] qa, qb;
        logic        rs;
        int          ndone, first_done, last_done;

        rst = 1'b1;
        s8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
        s16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sum16", {16'd0, sum16}, 32'd0);
        check("rst_busy16", {31'd0, busy16}, 32'd0);
        #2 rst = 1'b0;

        do_op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add_5a_3c");
        do_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        do_op8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
        do_op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");

        // Start pulse and operand change mid-operation must be ignored.
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0;
        @(negedge clk);
        s8 = 1'b0;
        repeat (2) @(negedge clk);
        s8 = 1'b1; a8 = 8'hFF; sub8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0; a8 = 8'hEE;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("restart_ignored_done_count", 32'(ndone), 32'd1);
        check("restart_ignored_sum", {24'd0, sum8}, 32'h33);

        // Reset after three bits: outputs clear immediately and no done follows.
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_sum", {24'd0, sum8}, 32'd0);
        check("abort_carry", {31'd0, carry8}, 32'd0);
        check("abort_ovf", {31'd0, ovf8}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < W8 + 3; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        do_op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_reset");

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            r = ref_op(W8, {24'd0, ra}, {24'd0, rb}, rs);
            do_op8(ra, rb, rs, r[7:0], r[32], r[33], "rand8");
        end

        // Start held high: a new operation every WIDTH+2 cycles.
        @(negedge clk);
        s8 = 1'b1;
        ndone = 0; first_done = -1; last_done = -1;
        for (int e = 0; e < 3 * (W8 + 2) + 1; e++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            @(negedge clk);
            if (done8) begin
                ndone++;
                if (first_done < 0) first_done = e;
                last_done = e;
            end
        end
        s8 = 1'b0;
        check("b2b_done_count", 32'(ndone), 32'd3);
        check("b2b_period", 32'(last_done - first_done), 32'(2 * (W8 + 2)));
        repeat (W8 + 3) @(negedge clk);

        do_op16(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, "w16_ffff_ffff");
        do_op16(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "w16_sub_8000_1");
        for (int n = 0; n < 8; n++) begin
            qa = 16'($urandom); qb = 16'($urandom); rs = 1'($urandom);
            r = ref_op(W16, {16'd0, qa}, {16'd0, qb}, rs);
            do_op16(qa, qb, rs, r[15:0], r[32], r[33], "rand16");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
